// File: rtl/vx_mem_req_arb.sv
// vx_mem_req_arb: round-robin merge of NUM_REQS memory request streams
// into one, through a 2-entry elastic buffer. Optional: VX_MEM_REQ_ARB_PERF_EN.
module vx_mem_req_arb #(
    parameter int NUM_REQS      = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int TAG_IN_WIDTH  = 8,
    parameter int DATA_SIZE     = DATA_WIDTH / 8,
    localparam int SIZE_WIDTH   = $clog2($clog2(DATA_SIZE) + 1),
    localparam int LOG_NUM_REQS = $clog2(NUM_REQS),
    localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + LOG_NUM_REQS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQS-1:0]              req_valid_in,
    input  logic [NUM_REQS-1:0]              req_rw_in,
    input  logic [NUM_REQS*DATA_SIZE-1:0]    req_byteen_in,
    input  logic [NUM_REQS*SIZE_WIDTH-1:0]   req_size_in,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]   req_addr_in,
    input  logic [NUM_REQS*DATA_WIDTH-1:0]   req_data_in,
    input  logic [NUM_REQS*TAG_IN_WIDTH-1:0] req_tag_in,
    output logic [NUM_REQS-1:0]              req_ready_in,
    output logic                             req_valid_out,
    output logic                             req_rw_out,
    output logic [DATA_SIZE-1:0]             req_byteen_out,
    output logic [SIZE_WIDTH-1:0]            req_size_out,
    output logic [ADDR_WIDTH-1:0]            req_addr_out,
    output logic [DATA_WIDTH-1:0]            req_data_out,
    output logic [TAG_OUT_WIDTH-1:0]         req_tag_out,
    input  logic                             req_ready_out
`ifdef VX_MEM_REQ_ARB_PERF_EN
    ,
    output logic [NUM_REQS*32-1:0]           perf_req_count,
    output logic [31:0]                      perf_stall_count
`endif
);

    localparam int IDX_W = (LOG_NUM_REQS > 0) ? LOG_NUM_REQS : 1;
    localparam int ENT_W = 1 + DATA_SIZE + SIZE_WIDTH + ADDR_WIDTH
                         + DATA_WIDTH + TAG_OUT_WIDTH;

    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         rr_nxt;
    logic [IDX_W-1:0]         grant_idx;
    logic                     grant_valid;
    logic [ENT_W-1:0]         buf_q [2];
    logic                     head;
    logic                     tail;
    logic [1:0]               count;
    logic                     push;
    logic                     pop;
    logic [TAG_OUT_WIDTH-1:0] tag_ext;
    logic [ENT_W-1:0]         push_ent;
    int                       ch;

    // Round-robin search starting at rr_ptr; first valid channel wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        ch          = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            ch = int'(rr_ptr) + k;
            if (ch >= NUM_REQS) begin
                ch = ch - NUM_REQS;
            end
            if (!grant_valid && req_valid_in[ch]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(ch);
            end
        end
    end

    assign push = reset && grant_valid && (count != 2'd2);
    assign pop  = req_valid_out && req_ready_out;

    // Only the granted channel sees ready, and only while there is room.
    always_comb begin
        req_ready_in = '0;
        if (push) begin
            req_ready_in[grant_idx] = 1'b1;
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next.
    always_comb begin
        rr_nxt = '0;
        if (NUM_REQS > 1) begin
            if (grant_idx != IDX_W'(NUM_REQS - 1)) begin
                rr_nxt = grant_idx + 1'b1;
            end
        end
    end

    generate
        if (NUM_REQS > 1) begin : g_tag_idx
            assign tag_ext = {req_tag_in[grant_idx*TAG_IN_WIDTH +: TAG_IN_WIDTH],
                              grant_idx};
        end else begin : g_tag_pass
            assign tag_ext = req_tag_in[TAG_IN_WIDTH-1:0];
        end
    endgenerate

    assign push_ent = {req_rw_in[grant_idx],
                       req_byteen_in[grant_idx*DATA_SIZE +: DATA_SIZE],
                       req_size_in[grant_idx*SIZE_WIDTH +: SIZE_WIDTH],
                       req_addr_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH],
                       req_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH],
                       tag_ext};

    // Elastic buffer: capture at tail on accept, release from head on pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            rr_ptr   <= '0;
            buf_q[0] <= '0;
            buf_q[1] <= '0;
        end else begin
            if (push) begin
                buf_q[tail] <= push_ent;
                tail        <= ~tail;
                rr_ptr      <= rr_nxt;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign req_valid_out = (count != 2'd0);
    assign {req_rw_out, req_byteen_out, req_size_out,
            req_addr_out, req_data_out, req_tag_out} = buf_q[head];

`ifdef VX_MEM_REQ_ARB_PERF_EN
    // Per-channel accept counters and downstream stall counter, wrapping.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_req_count   <= '0;
            perf_stall_count <= '0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (push && (grant_idx == IDX_W'(i))) begin
                    perf_req_count[i*32 +: 32] <= perf_req_count[i*32 +: 32] + 32'd1;
                end
            end
            if (req_valid_out && !req_ready_out) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vx_mem_req_arb.sv
// tb_vx_mem_req_arb: vector table, directed corner cases and randomized
// traffic checked against a queue-based model of the arbiter.
module tb_vx_mem_req_arb;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int TW  = 8;
    localparam int DS  = 8;
    localparam int SZW = 2;
    localparam int TOW = 10;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid;
    logic [N-1:0]    rw;
    logic [N*DS-1:0] byteen;
    logic [N*SZW-1:0] size;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N*TW-1:0] tag;
    logic [N-1:0]    ready_in;
    logic            valid_out;
    logic            rw_out;
    logic [DS-1:0]   byteen_out;
    logic [SZW-1:0]  size_out;
    logic [AW-1:0]   addr_out;
    logic [DW-1:0]   data_out;
    logic [TOW-1:0]  tag_out;
    logic            ready_out;
`ifdef VX_MEM_REQ_ARB_PERF_EN
    logic [N*32-1:0] perf_req;
    logic [31:0]     perf_stall;
`endif

    vx_mem_req_arb #(
        .NUM_REQS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_IN_WIDTH(TW)
    ) dut (
        .clk(clk), .reset(rst),
        .req_valid_in(valid), .req_rw_in(rw), .req_byteen_in(byteen),
        .req_size_in(size), .req_addr_in(addr), .req_data_in(data),
        .req_tag_in(tag), .req_ready_in(ready_in),
        .req_valid_out(valid_out), .req_rw_out(rw_out),
        .req_byteen_out(byteen_out), .req_size_out(size_out),
        .req_addr_out(addr_out), .req_data_out(data_out),
        .req_tag_out(tag_out), .req_ready_out(ready_out)
`ifdef VX_MEM_REQ_ARB_PERF_EN
        , .perf_req_count(perf_req), .perf_stall_count(perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic [DS-1:0] be;
        logic [SZW-1:0] sz;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [TOW-1:0] t;
    } ent_t;

    typedef struct {
        logic [N-1:0]   v;
        logic           rdy;
        logic [N-1:0]   e_rdy;
        logic           e_vo;
        logic [TOW-1:0] e_tag;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    bit   chk_en = 0;
    ent_t q[$];
    int   rr;
    int   m_acc[N];
    int   m_stall;
    int   obs[N];
    bit   p_pop, p_push, p_rst, p_stall;
    int   p_ch;
    ent_t p_ent;
    vec_t tbl[11];

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: evaluate expectations before the edge, plan the state change.
    task automatic plan();
        logic [N-1:0] e_rdy;
        ent_t o;
        e_rdy = '0;
        p_ch  = -1;
        if (rst && q.size() < 2) begin
            for (int k = 0; k < N; k++) begin
                if (p_ch < 0 && valid[(rr + k) % N]) p_ch = (rr + k) % N;
            end
        end
        if (p_ch >= 0) e_rdy[p_ch] = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (ready_in[i] && valid[i]) obs[i]++;
        end
        if (chk_en) begin
            check("ready_in", 128'(ready_in), 128'(e_rdy));
            check("valid_out", 128'(valid_out), 128'(q.size() != 0));
            if (q.size() != 0) begin
                o = {rw_out, byteen_out, size_out, addr_out, data_out, tag_out};
                check("payload", 128'(o), 128'(q[0]));
            end
        end
        p_rst   = !rst;
        p_pop   = rst && q.size() != 0 && ready_out;
        p_stall = rst && q.size() != 0 && !ready_out;
        p_push  = p_ch >= 0;
        if (p_push) begin
            p_ent.rw = rw[p_ch];
            p_ent.be = byteen[p_ch*DS +: DS];
            p_ent.sz = size[p_ch*SZW +: SZW];
            p_ent.a  = addr[p_ch*AW +: AW];
            p_ent.d  = data[p_ch*DW +: DW];
            p_ent.t  = {tag[p_ch*TW +: TW], 2'(p_ch)};
        end
    endtask

    task automatic commit();
        if (p_rst) begin
            q.delete();
            rr = 0;
            m_stall = 0;
            for (int i = 0; i < N; i++) m_acc[i] = 0;
        end else begin
            if (p_pop) void'(q.pop_front());
            if (p_push) begin
                q.push_back(p_ent);
                rr = (p_ch + 1) % N;
                m_acc[p_ch]++;
            end
            if (p_stall) m_stall++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        plan();
        @(posedge clk);
        #1;
        commit();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        valid = '0;
        step();
        chk_en = 1;
        step();
        rst = 1'b1;
    endtask

    task automatic fixed_payload();
        for (int i = 0; i < N; i++) begin
            rw[i] = i[0];
            byteen[i*DS +: DS] = 8'(8'hF0 >> i);
            size[i*SZW +: SZW] = 2'(i);
            addr[i*AW +: AW] = 32'h1000 * (i + 1);
            data[i*DW +: DW] = {32'hDEAD0000 + 32'(i), 32'h0};
            tag[i*TW +: TW] = 8'(8'h10 + i);
        end
    endtask

    task automatic rand_payload();
        rw = N'($urandom);
        byteen = {$urandom, $urandom};
        size = 8'($urandom);
        addr = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 2 * N; i++) data[i*32 +: 32] = $urandom;
        tag = $urandom;
    endtask

    initial begin
        tbl[0]  = '{4'hF, 1'b0, 4'b0001, 1'b0, 10'h000};
        tbl[1]  = '{4'hF, 1'b0, 4'b0010, 1'b1, 10'h040};
        tbl[2]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 10'h040};
        tbl[3]  = '{4'hF, 1'b0, 4'b0000, 1'b1, 10'h040};
        tbl[4]  = '{4'hF, 1'b1, 4'b0000, 1'b1, 10'h040};
        tbl[5]  = '{4'hF, 1'b1, 4'b0100, 1'b1, 10'h045};
        tbl[6]  = '{4'hF, 1'b1, 4'b1000, 1'b1, 10'h04A};
        tbl[7]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 10'h04F};
        tbl[8]  = '{4'h4, 1'b1, 4'b0100, 1'b0, 10'h000};
        tbl[9]  = '{4'h0, 1'b1, 4'b0000, 1'b1, 10'h04A};
        tbl[10] = '{4'h0, 1'b1, 4'b0000, 1'b0, 10'h000};

        rst = 1'b0;
        valid = '0;
        ready_out = 1'b0;
        fixed_payload();
        @(posedge clk);
        #1;
        do_reset();

        // Vector table: backpressure, hold, release, order.
        for (int r = 0; r < 11; r++) begin
            valid = tbl[r].v;
            ready_out = tbl[r].rdy;
            #1;
            check("tbl_ready_in", 128'(ready_in), 128'(tbl[r].e_rdy));
            check("tbl_valid_out", 128'(valid_out), 128'(tbl[r].e_vo));
            if (tbl[r].e_vo) check("tbl_tag_out", 128'(tag_out), 128'(tbl[r].e_tag));
            step();
        end

        // Single request through channel 2.
        do_reset();
        addr[2*AW +: AW] = 32'h1000;
        tag[2*TW +: TW] = 8'h5A;
        valid = 4'b0100;
        ready_out = 1'b1;
        #1;
        check("single_ready", 128'(ready_in), 128'(4'b0100));
        step();
        valid = '0;
        #1;
        check("single_valid", 128'(valid_out), 128'(1));
        check("single_addr", 128'(addr_out), 128'(32'h1000));
        check("single_tag", 128'(tag_out), 128'(10'h16A));
        step();
        check("single_gone", 128'(valid_out), 128'(0));

        // Fairness with all channels valid.
        fixed_payload();
        do_reset();
        for (int i = 0; i < N; i++) obs[i] = 0;
        valid = '1;
        ready_out = 1'b1;
        for (int c = 0; c < 40; c++) step();
        for (int i = 0; i < N; i++) check($sformatf("fair_ch%0d", i), 128'(obs[i]), 128'(10));

        // Reset mid-stream with the buffer full.
        do_reset();
        valid = '1;
        ready_out = 1'b0;
        step();
        step();
        check("full_valid", 128'(valid_out), 128'(1));
        rst = 1'b0;
        #1;
        check("rst_ready_in", 128'(ready_in), 128'(0));
        step();
        rst = 1'b1;
        valid = '0;
        #1;
        check("rst_valid_out", 128'(valid_out), 128'(0));
        check("rst_payload", 128'({rw_out, byteen_out, size_out, addr_out,
                                   data_out, tag_out}), 128'(0));
        valid = '1;
        #1;
        check("rst_ch0_first", 128'(ready_in), 128'(4'b0001));
        step();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 300; c++) begin
            valid = N'($urandom);
            ready_out = ($urandom_range(0, 3) != 0);
            rand_payload();
            step();
        end
        // Streaming: downstream always ready.
        ready_out = 1'b1;
        for (int c = 0; c < 100; c++) begin
            valid = N'($urandom);
            rand_payload();
            step();
            check("stream_depth", 128'(q.size() <= 1), 128'(1));
        end

`ifdef VX_MEM_REQ_ARB_PERF_EN
        for (int i = 0; i < N; i++)
            check($sformatf("perf_rand_ch%0d", i), 128'(perf_req[i*32 +: 32]),
                  128'(m_acc[i]));
        check("perf_rand_stall", 128'(perf_stall), 128'(m_stall));
        do_reset();
        valid = 4'b0010;
        ready_out = 1'b1;
        for (int c = 0; c < 5; c++) step();
        valid = '0;
        ready_out = 1'b0;
        for (int c = 0; c < 3; c++) step();
        ready_out = 1'b1;
        step();
        check("perf_ch1", 128'(perf_req[32 +: 32]), 128'(5));
        check("perf_ch0", 128'(perf_req[0 +: 32]), 128'(0));
        check("perf_stall", 128'(perf_stall), 128'(3));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
